// File: rtl/shk_arbiter_if.sv
// Shake bus bundle seen by the round-robin arbiter: the NUM_PORT requester
// side (s_*), the single downstream target side (m_*) and the error-info port.
// The "master" modport is the arbiter's view (it masters the downstream bus);
// the "slave" modport is the view of the surrounding requesters and target.
interface shk_arbiter_if #(
    parameter int NUM_PORT    = 4,
    parameter int WD_SHK_SYNC = 16,
    parameter int WD_SHK_DLAY = 15,
    parameter int WD_ERR_INFO = 4
);
    logic [NUM_PORT-1:0]             s_shk_arb_wvalid;
    logic [NUM_PORT*WD_SHK_SYNC-1:0] s_shk_arb_smosi;
    logic [NUM_PORT*WD_SHK_DLAY-1:0] s_shk_arb_dmosi;
    logic [NUM_PORT-1:0]             s_shk_arb_wready;
    logic [NUM_PORT*WD_SHK_SYNC-1:0] s_shk_arb_smiso;
    logic [NUM_PORT*WD_SHK_DLAY-1:0] s_shk_arb_dmiso;

    logic                            m_shk_arb_wvalid;
    logic [WD_SHK_SYNC-1:0]          m_shk_arb_smosi;
    logic [WD_SHK_DLAY-1:0]          m_shk_arb_dmosi;
    logic                            m_shk_arb_wready;
    logic [WD_SHK_SYNC-1:0]          m_shk_arb_smiso;
    logic [WD_SHK_DLAY-1:0]          m_shk_arb_dmiso;

    logic [WD_ERR_INFO-1:0]          m_err_arb_info1;

    modport master (
        input  s_shk_arb_wvalid, s_shk_arb_smosi, s_shk_arb_dmosi,
        output s_shk_arb_wready, s_shk_arb_smiso, s_shk_arb_dmiso,
        output m_shk_arb_wvalid, m_shk_arb_smosi, m_shk_arb_dmosi,
        input  m_shk_arb_wready, m_shk_arb_smiso, m_shk_arb_dmiso,
        output m_err_arb_info1
    );

    modport slave (
        output s_shk_arb_wvalid, s_shk_arb_smosi, s_shk_arb_dmosi,
        input  s_shk_arb_wready, s_shk_arb_smiso, s_shk_arb_dmiso,
        input  m_shk_arb_wvalid, m_shk_arb_smosi, m_shk_arb_dmosi,
        output m_shk_arb_wready, m_shk_arb_smiso, m_shk_arb_dmiso,
        input  m_err_arb_info1
    );
endinterface

// File: rtl/shk_arbiter.sv
// Round-robin arbiter sharing one shake master port between NUM_PORT
// requesters, with a per-transaction timeout that frees a hung target.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transaction; pick next requester from rr_ptr upward
// ISSUE  | m_wvalid high, waiting for m_wready or timeout
// RESP   | one-cycle s_wready to the granted port, advance rr_ptr
module shk_arbiter #(
    parameter int WD_SHK_SYNC = 16,
    parameter int WD_SHK_DLAY = 15,
    parameter int WD_ERR_INFO = 4,
    parameter int NUM_PORT    = 4,
    parameter int TIMEOUT     = 1023
) (
    input logic           i_sys_clk,
    input logic           i_sys_resetn,
    shk_arbiter_if.master shk_bus
);
    localparam int IW = $clog2(NUM_PORT);
    localparam int EW = WD_ERR_INFO - 2;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    // Counter value during the last cycle m_wvalid may stay high.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [IW-1:0]                   grant_q, grant_d;
    logic [IW-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [WD_SHK_SYNC-1:0]          m_smosi_q, m_smosi_d;
    logic [WD_SHK_DLAY-1:0]          m_dmosi_q, m_dmosi_d;
    logic [NUM_PORT*WD_SHK_SYNC-1:0] s_smiso_q, s_smiso_d;
    logic [NUM_PORT*WD_SHK_DLAY-1:0] s_dmiso_q, s_dmiso_d;
    logic                            err_pulse_q, err_pulse_d;
    logic                            err_sticky_q, err_sticky_d;
    logic [EW-1:0]                   err_idx_q, err_idx_d;

    logic                            pick_vld;
    logic [IW-1:0]                   pick_idx;
    logic [IW-1:0]                   scan_idx;
    logic                            timeout_hit;
    logic                            m_wvalid_c;
    logic [NUM_PORT-1:0]             s_wready_c;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Round-robin search: first requesting port at or above rr_ptr, with wrap.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
            scan_idx = IW'((int'(rr_ptr_q) + k) % NUM_PORT);
            if (!pick_vld && shk_bus.s_shk_arb_wvalid[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            m_smosi_q    <= '0;
            m_dmosi_q    <= '0;
            s_smiso_q    <= '0;
            s_dmiso_q    <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            m_smosi_q    <= m_smosi_d;
            m_dmosi_q    <= m_dmosi_d;
            s_smiso_q    <= s_smiso_d;
            s_dmiso_q    <= s_dmiso_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_idx_q    <= err_idx_d;
        end
    end

    // Next-state logic; m_wready wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_vld) state_d = ST_ISSUE;
            ST_ISSUE: if (shk_bus.m_shk_arb_wready || timeout_hit) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: grant latch, response capture, timeout reporting.
    always_comb begin
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        m_smosi_d    = m_smosi_q;
        m_dmosi_d    = m_dmosi_q;
        s_smiso_d    = s_smiso_q;
        s_dmiso_d    = s_dmiso_q;
        err_pulse_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        err_idx_d    = err_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d   = pick_idx;
                    m_smosi_d = shk_bus.s_shk_arb_smosi[pick_idx*WD_SHK_SYNC +: WD_SHK_SYNC];
                    m_dmosi_d = shk_bus.s_shk_arb_dmosi[pick_idx*WD_SHK_DLAY +: WD_SHK_DLAY];
                    cnt_d     = '0;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + CW'(1);
                if (shk_bus.m_shk_arb_wready) begin
                    s_smiso_d[grant_q*WD_SHK_SYNC +: WD_SHK_SYNC] = shk_bus.m_shk_arb_smiso;
                    s_dmiso_d[grant_q*WD_SHK_DLAY +: WD_SHK_DLAY] = shk_bus.m_shk_arb_dmiso;
                end else if (timeout_hit) begin
                    s_smiso_d[grant_q*WD_SHK_SYNC +: WD_SHK_SYNC] = '0;
                    s_dmiso_d[grant_q*WD_SHK_DLAY +: WD_SHK_DLAY] = '0;
                    err_pulse_d  = 1'b1;
                    err_sticky_d = 1'b1;
                    err_idx_d    = EW'(grant_q);
                end
            end
            ST_RESP: begin
                rr_ptr_d = (grant_q == IW'(NUM_PORT - 1)) ? '0 : grant_q + IW'(1);
            end
            default: ;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        m_wvalid_c = (state_q == ST_ISSUE);
        s_wready_c = '0;
        if (state_q == ST_RESP) s_wready_c[grant_q] = 1'b1;
    end

    assign shk_bus.m_shk_arb_wvalid = m_wvalid_c;
    assign shk_bus.m_shk_arb_smosi  = m_smosi_q;
    assign shk_bus.m_shk_arb_dmosi  = m_dmosi_q;
    assign shk_bus.s_shk_arb_wready = s_wready_c;
    assign shk_bus.s_shk_arb_smiso  = s_smiso_q;
    assign shk_bus.s_shk_arb_dmiso  = s_dmiso_q;
    assign shk_bus.m_err_arb_info1  = {err_idx_q, err_sticky_q, err_pulse_q};
endmodule
